// File: rtl/student_coeff_ctrl.sv
// Coefficient sweep controller: streams N coefficients from a dual-port RAM to the MAC
// datapath per input sample, and arbitrates host writes so they never land mid-sweep.
module student_coeff_ctrl #(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned CoeffDataSize = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  output logic                     sample_ready_o,
  input  logic [AddrWidth:0]       num_taps_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [AddrWidth-1:0]     wr_addr_i,
  input  logic [CoeffDataSize-1:0] wr_data_i,
  output logic                     ram_ena_o,
  output logic                     ram_wea_o,
  output logic [AddrWidth-1:0]     ram_addra_o,
  output logic [CoeffDataSize-1:0] ram_dia_o,
  output logic                     ram_enb_o,
  output logic [AddrWidth-1:0]     ram_addrb_o,
  input  logic [CoeffDataSize-1:0] ram_dob_i,
  output logic [CoeffDataSize-1:0] coeff_o,
  output logic                     coeff_valid_o,
  output logic [AddrWidth-1:0]     coeff_idx_o,
  output logic                     coeff_last_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [AddrWidth-1:0] last_q, last_d;
  logic [AddrWidth-1:0] idx_q;
  logic                 valid_q, last_flag_q, done_q;

  logic                 accept, taps_zero, run_last, wr_fire;
  logic [AddrWidth-1:0] taps_last;

  // Requests above the RAM depth saturate to a full sweep, so the last index is all ones.
  assign taps_zero = (num_taps_i == '0);
  assign taps_last = num_taps_i[AddrWidth] ? '1 : (num_taps_i[AddrWidth-1:0] - 1'b1);

  assign sample_ready_o = (state_q == StIdle) && !rst_i;
  assign accept         = sample_ready_o && sample_valid_i;
  assign wr_ready_o     = sample_ready_o && !sample_valid_i;
  assign wr_fire        = wr_ready_o && wr_valid_i;

  assign ram_ena_o   = wr_fire;
  assign ram_wea_o   = wr_fire;
  assign ram_addra_o = wr_addr_i;
  assign ram_dia_o   = wr_data_i;

  assign ram_enb_o   = (state_q == StRun) && !rst_i;
  assign ram_addrb_o = cnt_q;
  assign run_last    = ram_enb_o && (cnt_q == last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (sample_valid_i) begin
          cnt_d  = '0;
          last_d = taps_last;
          if (!taps_zero) state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == last_q) state_d = StDrain;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      valid_q     <= ram_enb_o;
      last_flag_q <= run_last;
      done_q      <= run_last || (accept && taps_zero);
      if (ram_enb_o) idx_q <= cnt_q;
    end
  end

  // Registered outputs are masked during reset so an aborted sweep stops immediately.
  assign coeff_o       = ram_dob_i;
  assign coeff_valid_o = valid_q && !rst_i;
  assign coeff_idx_o   = rst_i ? '0 : idx_q;
  assign coeff_last_o  = last_flag_q && !rst_i;
  assign done_o        = done_q && !rst_i;

endmodule

// File: tb/tb_student_coeff_ctrl.sv
// Randomised and directed checks of student_coeff_ctrl against a cycle-count based sweep model.
module tb_student_coeff_ctrl;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [AW:0]   num_taps = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia, ram_dob, coeff;
  logic          coeff_valid, coeff_last, done;
  logic [AW-1:0] coeff_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  student_coeff_ctrl #(.AddrWidth(AW), .CoeffDataSize(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .sample_valid_i(sample_valid), .sample_ready_o(sample_ready), .num_taps_i(num_taps),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ram_ena_o(ram_ena), .ram_wea_o(ram_wea), .ram_addra_o(ram_addra), .ram_dia_o(ram_dia),
    .ram_enb_o(ram_enb), .ram_addrb_o(ram_addrb), .ram_dob_i(ram_dob),
    .coeff_o(coeff), .coeff_valid_o(coeff_valid), .coeff_idx_o(coeff_idx),
    .coeff_last_o(coeff_last), .done_o(done)
  );

  // Simple synchronous dual-port RAM, one-cycle read latency.
  bit [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_enb) ram_dob <= mem[ram_addrb];
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a sweep accepted at cycle T with N taps occupies cycles T+1..T+N+1; m_k counts
  // cycles since acceptance. Coefficients shadowed from the host writes the model expects.
  bit [DW-1:0] coef_m [DEPTH];
  bit          m_busy = 0;
  bit          m_zero = 0;
  int          m_k = 0;
  int          m_n = 0;

  always @(negedge clk) begin
    bit e_ready, e_wrr, e_wr, e_enb, e_val, e_last, e_done;
    int n;
    e_ready = !rst && !m_busy;
    e_wrr   = e_ready && !sample_valid;
    e_wr    = e_wrr && wr_valid;
    e_enb   = !rst && m_busy && (m_k <= m_n);
    e_val   = !rst && m_busy && (m_k >= 2);
    e_last  = e_val && (m_k == m_n + 1);
    e_done  = !rst && (e_last || m_zero);
    chk("sample_ready", 32'(sample_ready), 32'(e_ready));
    chk("wr_ready", 32'(wr_ready), 32'(e_wrr));
    chk("ram_ena", 32'(ram_ena), 32'(e_wr));
    chk("ram_wea", 32'(ram_wea), 32'(e_wr));
    chk("ram_enb", 32'(ram_enb), 32'(e_enb));
    chk("coeff_valid", 32'(coeff_valid), 32'(e_val));
    chk("coeff_last", 32'(coeff_last), 32'(e_last));
    chk("done", 32'(done), 32'(e_done));
    if (e_wr) begin
      chk("ram_addra", 32'(ram_addra), 32'(wr_addr));
      chk("ram_dia", 32'(ram_dia), 32'(wr_data));
    end
    if (e_enb) chk("ram_addrb", 32'(ram_addrb), 32'(m_k - 1));
    if (e_val) begin
      chk("coeff_idx", 32'(coeff_idx), 32'(m_k - 2));
      chk("coeff", 32'(coeff), 32'(coef_m[m_k - 2]));
    end
    if (rst) chk("coeff_idx_rst", 32'(coeff_idx), 32'd0);

    if (rst) begin
      m_busy = 0;
      m_zero = 0;
    end else begin
      m_zero = 0;
      if (m_busy) begin
        if (m_k == m_n + 1) m_busy = 0;
        else                m_k++;
      end else if (sample_valid) begin
        n = (int'(num_taps) > DEPTH) ? DEPTH : int'(num_taps);
        if (n == 0) m_zero = 1;
        else begin
          m_busy = 1;
          m_k    = 1;
          m_n    = n;
        end
      end
      if (e_wr) coef_m[wr_addr] = wr_data;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int last_idx;
    repeat (3) next();
    rst = 1'b0;

    // Load 1..8 then sweep 8 taps with literal expectations.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(i);
      wr_data  = DW'(i + 1);
      next();
    end
    wr_valid     = 1'b0;
    sample_valid = 1'b1;
    num_taps     = 6'd8;
    @(negedge clk);
    chk("lit_ready_T", 32'(sample_ready), 32'd1);
    next();
    sample_valid = 1'b0;
    num_taps     = 6'd3;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        chk("lit_coeff", 32'(coeff), 32'(j - 1));
        chk("lit_idx", 32'(coeff_idx), 32'(j - 2));
      end
      if (j == 9) begin
        chk("lit_done", 32'(done), 32'd1);
        chk("lit_last", 32'(coeff_last), 32'd1);
      end
      next();
    end
    @(negedge clk);
    chk("lit_ready_T10", 32'(sample_ready), 32'd1);

    // Write held during a 4-tap sweep lands in the first idle cycle.
    sample_valid = 1'b1;
    num_taps     = 6'd4;
    next();
    sample_valid = 1'b0;
    wr_valid     = 1'b1;
    wr_addr      = 5'd3;
    wr_data      = 16'hBEEF;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("lit_wea_stalled", 32'(ram_wea), 32'd0);
      next();
    end
    @(negedge clk);
    chk("lit_wea_lands", 32'(ram_wea), 32'd1);
    next();
    wr_valid = 1'b0;

    // Sweep and write requested together: sweep wins, write waits until after drain.
    sample_valid = 1'b1;
    num_taps     = 6'd2;
    wr_valid     = 1'b1;
    wr_addr      = 5'd0;
    wr_data      = 16'h1234;
    @(negedge clk);
    chk("lit_wr_ready_prio", 32'(wr_ready), 32'd0);
    next();
    sample_valid = 1'b0;
    repeat (3) next();
    @(negedge clk);
    chk("lit_wea_after_drain", 32'(ram_wea), 32'd1);
    next();
    wr_valid = 1'b0;

    // Zero taps: immediate done, no reads.
    sample_valid = 1'b1;
    num_taps     = 6'd0;
    next();
    sample_valid = 1'b0;
    @(negedge clk);
    chk("lit_zero_done", 32'(done), 32'd1);
    chk("lit_zero_enb", 32'(ram_enb), 32'd0);
    next();

    // Oversized request saturates to a full-depth sweep.
    sample_valid = 1'b1;
    num_taps     = 6'(DEPTH + 5);
    next();
    sample_valid = 1'b0;
    cnt      = 0;
    last_idx = -1;
    for (int j = 0; j < DEPTH + 8; j++) begin
      @(negedge clk);
      if (ram_enb) cnt++;
      if (coeff_last) last_idx = int'(coeff_idx);
      next();
    end
    chk("lit_sat_reads", 32'(cnt), 32'(DEPTH));
    chk("lit_sat_last_idx", 32'(last_idx), 32'(DEPTH - 1));

    // Reset at T+4 of an 8-tap sweep aborts it.
    sample_valid = 1'b1;
    num_taps     = 6'd8;
    next();
    sample_valid = 1'b0;
    repeat (3) next();
    rst = 1'b1;
    next();
    @(negedge clk);
    chk("lit_abort_valid", 32'(coeff_valid), 32'd0);
    next();
    rst = 1'b0;
    sample_valid = 1'b1;
    num_taps     = 6'd3;
    @(negedge clk);
    chk("lit_ready_after_rst", 32'(sample_ready), 32'd1);
    next();
    sample_valid = 1'b0;
    next();
    @(negedge clk);
    chk("lit_restart_coeff", 32'(coeff), 32'h1234);
    chk("lit_restart_idx", 32'(coeff_idx), 32'd0);
    next();
    repeat (4) next();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      sample_valid = ($urandom % 4 == 0);
      num_taps     = ($urandom % 8 == 0) ? 6'($urandom_range(DEPTH, DEPTH + 5))
                                         : 6'($urandom_range(0, 9));
      wr_valid     = ($urandom % 2 == 0);
      wr_addr      = AW'($urandom);
      wr_data      = DW'($urandom);
      rst          = ($urandom % 60 == 0);
      next();
    end
    sample_valid = 1'b0;
    wr_valid     = 1'b0;
    rst          = 1'b0;
    repeat (DEPTH + 8) next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/student_coeff_ctrl.md
STUDENT_COEFF_CTRL -- requirements
Module: student_coeff_ctrl

Interface
REQ-001 SHALL have parameter AddrWidth, default 10: coefficient RAM address width.
REQ-002 SHALL have parameter CoeffDataSize, default 16: coefficient word width.
REQ-003 SHALL use one clock and one synchronous, active-high reset.
REQ-004 SHALL have the following ports:
- clk_i  in  1  sole clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- sample_valid_i  in  1  request one coefficient sweep (new input sample)
- sample_ready_o  out  1  sweep request accepted when high with sample_valid_i
- num_taps_i  in  AddrWidth+1  taps per sweep, sampled at acceptance
- wr_valid_i  in  1  host coefficient write request
- wr_ready_o  out  1  host write accepted when high with wr_valid_i
- wr_addr_i  in  AddrWidth  host write address
- wr_data_i  in  CoeffDataSize  host write data
- ram_ena_o, ram_wea_o  out  1 each  RAM port-A enable/write-enable
- ram_addra_o  out  AddrWidth  RAM port-A address
- ram_dia_o  out  CoeffDataSize  RAM port-A write data
- ram_enb_o  out  1  RAM port-B read enable
- ram_addrb_o  out  AddrWidth  RAM port-B read address
- ram_dob_i  in  CoeffDataSize  RAM read data, valid one cycle after ram_enb_o
- coeff_o  out  CoeffDataSize  coefficient to MAC datapath
- coeff_valid_o  out  1  coeff_o valid
- coeff_idx_o  out  AddrWidth  tap index of coeff_o
- coeff_last_o  out  1  final coefficient of sweep
- done_o  out  1  one-cycle pulse, sweep complete

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-006 sample_ready_o SHALL be 1 only in IDLE.
REQ-007 In IDLE with sample_valid_i=1 (accept cycle T), SHALL latch N = min(num_taps_i, 2**AddrWidth).
REQ-008 If N=0: SHALL issue no reads, pulse done_o at T+1, stay IDLE.
REQ-009 Otherwise SHALL go to RUN; cycles T+1..T+N drive ram_enb_o=1 and ram_addrb_o=0,1,...,N-1.
REQ-010 After the read of address N-1, SHALL go to DRAIN for one cycle (T+N+1), then return to IDLE.
REQ-011 coeff_valid_o SHALL be ram_enb_o delayed one cycle (high T+2..T+N+1); coeff_o SHALL equal ram_dob_i (combinational).
REQ-012 coeff_idx_o SHALL be the registered read address; coeff_last_o=1 only with index N-1.
REQ-013 done_o SHALL pulse in the same cycle as coeff_last_o (T+N+1) for N>=1.
REQ-014 ram_enb_o SHALL be 0 in IDLE and DRAIN.
REQ-015 wr_ready_o SHALL be 1 iff state==IDLE and sample_valid_i==0; a sweep request has priority over a write.
REQ-016 On a write handshake, SHALL drive ram_ena_o=ram_wea_o=1, ram_addra_o=wr_addr_i, ram_dia_o=wr_data_i in the same cycle; otherwise ram_ena_o=ram_wea_o=0.
REQ-017 No RAM write SHALL occur while in RUN or DRAIN, so that every sweep sees one consistent coefficient set.
REQ-018 num_taps_i changes after acceptance SHALL NOT affect the current sweep.
REQ-019 Back-to-back sweeps: the next acceptance SHALL occur at earliest T+N+2.

Reset
REQ-020 While rst_i=1: state=IDLE, counter=0; ram_enb_o, ram_ena_o, ram_wea_o, coeff_valid_o, coeff_last_o, done_o, coeff_idx_o = 0; sample_ready_o and wr_ready_o = 0.
REQ-021 Reset mid-sweep SHALL abort the sweep: no further coeff_valid_o, no done_o; RAM contents unchanged.
REQ-022 The first cycle after rst_i falls SHALL be IDLE and accept requests.

Verification
REQ-023 Load 0x0001..0x0008 to addresses 0..7 via writes, num_taps_i=8, sample at T -> coeff_o 0x0001..0x0008, idx 0..7, valid T+2..T+9, last+done at T+9, ready again at T+10.
REQ-024 wr_valid_i held during RUN -> wr_ready_o=0 and no ram_wea_o until IDLE; the write lands in the first IDLE cycle without sample_valid_i.
REQ-025 sample_valid_i and wr_valid_i both high in IDLE -> sweep accepted, write stalled until after DRAIN.
REQ-026 num_taps_i=0 -> done_o at T+1, no ram_enb_o, no coeff_valid_o; num_taps_i=2**AddrWidth+5 -> 2**AddrWidth reads, last idx 2**AddrWidth-1.
REQ-027 rst_i asserted at T+4 of an 8-tap sweep -> coeff_valid_o=0 from T+5, no done_o; a new sweep after reset runs correctly from address 0.
